regread_stage: RTL and testbench
================================

REGREAD_STAGE -- requirements
Module: regread_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the operand, immediate and write-back data width.
REQ-002 Parameter NREGS, default 8, SHALL set the register count; register index width is clog2(NREGS), 3 by default.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  decoded instruction present.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 in_cop  in  4  ALU operation code, passed through unchanged.
REQ-008 in_rs_a, in_rs_b  in  IDX  source register indices.
REQ-009 in_rd  in  IDX  destination register index.
REQ-010 in_wr  in  1  instruction writes in_rd.
REQ-011 in_use_imm  in  1  operand B is taken from in_imm instead of in_rs_b.
REQ-012 in_imm  in  DATA_WIDTH  immediate value.
REQ-013 wb_en, wb_rd, wb_data  in  1/IDX/DATA_WIDTH  write-back port from the ALU result.
REQ-014 flush  in  1  discard the held instruction and all pending writes.
REQ-015 out_valid  out  1  operands held for the ALU.
REQ-016 out_ready  in  1  downstream ALU stage consumes the held instruction.
REQ-017 out_reg_A, out_reg_B  out  DATA_WIDTH  ALU operands.
REQ-018 out_cop  out  4  ALU opcode.
REQ-019 out_rd, out_wr  out  IDX/1  destination index and write flag, passed through.

Function
REQ-020 The register file SHALL hold NREGS words of DATA_WIDTH bits; if wb_en is 1, wb_data SHALL be written to wb_rd at the clock edge.
REQ-021 Reads SHALL be combinational with write-through: if wb_en is 1 and wb_rd matches a source index in the same cycle, that source SHALL read wb_data.
REQ-022 A scoreboard SHALL hold one busy bit per register.
REQ-023 hazard SHALL be 1 when busy[in_rs_a] is 1, or when in_use_imm is 0 and busy[in_rs_b] is 1.
  - A busy bit being cleared by wb_en in the same cycle SHALL count as not busy.
REQ-024 in_ready SHALL equal (out_ready OR NOT out_valid) AND NOT hazard AND NOT flush.
REQ-025 An instruction SHALL be accepted when in_valid and in_ready are both 1.
  - On acceptance, the output register SHALL load the operands, in_cop, in_rd and in_wr, and out_valid SHALL become 1 one cycle later.
  - Read-to-output latency is therefore exactly 1 cycle.
REQ-026 out_reg_B SHALL be in_imm when in_use_imm is 1, otherwise the register read value.
REQ-027 When out_valid and out_ready are 1 and no new instruction is accepted, out_valid SHALL become 0.
REQ-028 While out_valid is 1 and out_ready is 0, all out_* signals SHALL hold stable.
REQ-029 On acceptance with in_wr = 1, busy[in_rd] SHALL be set.
REQ-030 wb_en SHALL clear busy[wb_rd].
  - If the set and the clear target the same register in the same cycle, set SHALL win.
REQ-031 flush SHALL clear out_valid and every busy bit at the next edge.
  - flush SHALL dominate any acceptance in that cycle.
  - A wb_en in the same cycle SHALL still write the register file.
REQ-032 Register index 0 SHALL get no special treatment; it is an ordinary register.

Reset
REQ-033 While rst_n is 0, the stage SHALL immediately force:
  - out_valid, all busy bits, out_reg_A, out_reg_B, out_cop, out_rd and out_wr to 0;
  - every register-file word to 0.
REQ-034 A reset asserted mid-operation SHALL discard any held instruction with no partial write.
REQ-035 After rst_n deasserts, in_ready SHALL be 1 when flush is 0.

Structure
REQ-036 A shared package SHALL hold DATA_WIDTH, NREGS, the index width and the 4-bit opcode constants (NOP 0000, ADD 0001, SUB 0010, MOVB 0011, CMPEQ 0100).
REQ-037 The register file SHALL be the single sub-module regfile: one write port, two bypassed read ports, asynchronous active-low reset.
REQ-038 The scoreboard and output register SHALL stay in regread_stage.

Verification
REQ-039 Reset test: reset, then wb r3 = 0x1234; next cycle issue ADD rs_a=3, rs_b=0 -> out_reg_A = 0x1234, out_reg_B = 0x0000, out_cop = 0001, 1 cycle later.
REQ-040 Bypass test: wb r2 = 0xBEEF in the same cycle as issuing rs_a=2 -> out_reg_A = 0xBEEF.
REQ-041 RAW hazard test: issue in_wr=1 with rd=5, then issue rs_a=5 -> in_ready = 0 until wb_en with wb_rd=5; the consumer is accepted in that wb cycle with operand = wb_data.
REQ-042 Stall test: out_ready = 0 for 3 cycles with a held instruction -> out_* stable, in_ready = 0; out_ready = 1 -> next instruction accepted the same cycle.
REQ-043 Flush test: flush with out_valid = 1 and r4 busy -> out_valid = 0 and busy clear next cycle; an rs_a=4 issue is then accepted immediately.
REQ-044 Immediate test: in_use_imm = 1, imm = 0xFFFF, rs_b busy -> no stall, out_reg_B = 0xFFFF.

Source files
------------

// File: rtl/regread_stage_pkg.sv
// Shared sizing and opcode constants for the register-read stage.
package regread_stage_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int NREGS      = 8;
  localparam int IDX_W      = $clog2(NREGS);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MOVB  = 4'b0011;
  localparam logic [3:0] OP_CMPEQ = 4'b0100;
endpackage

// File: rtl/regread_stage_regfile.sv
// Register file: one write port, two combinational read ports with write-through.
module regfile
  import regread_stage_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int NR = NREGS,
  parameter int IW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr_a,
  input  logic [IW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);
  logic [NR-1:0][DW-1:0] mem_q, mem_d;

  // Next-state storage: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage flops; reset clears every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  // Reads see a same-cycle write so a consumer never waits an extra cycle.
  always_comb begin
    rdata_a = (we && waddr == raddr_a) ? wdata : mem_q[raddr_a];
    rdata_b = (we && waddr == raddr_b) ? wdata : mem_q[raddr_b];
  end
endmodule

// File: rtl/regread_stage.sv
// Register-read stage: scoreboard hazard check, operand fetch, output register.
module regread_stage
  import regread_stage_pkg::*;
#(
  parameter int DATA_WIDTH = regread_stage_pkg::DATA_WIDTH,
  parameter int NREGS      = regread_stage_pkg::NREGS,
  parameter int IDX        = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_cop,
  input  logic [IDX-1:0]        in_rs_a,
  input  logic [IDX-1:0]        in_rs_b,
  input  logic [IDX-1:0]        in_rd,
  input  logic                  in_wr,
  input  logic                  in_use_imm,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  wb_en,
  input  logic [IDX-1:0]        wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_reg_A,
  output logic [DATA_WIDTH-1:0] out_reg_B,
  output logic [3:0]            out_cop,
  output logic [IDX-1:0]        out_rd,
  output logic                  out_wr
);
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic [NREGS-1:0]      busy_q, busy_d, busy_eff;
  logic                  hazard, accept;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [3:0]            out_cop_q, out_cop_d;
  logic [IDX-1:0]        out_rd_q, out_rd_d;
  logic                  out_wr_q, out_wr_d;

  regfile #(.DW(DATA_WIDTH), .NR(NREGS), .IW(IDX)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (in_rs_a),
    .raddr_b (in_rs_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Busy view for this cycle: a register being written back now is already free.
  always_comb begin
    busy_eff = busy_q;
    for (int i = 0; i < NREGS; i++)
      if (wb_en && wb_rd == IDX'(i)) busy_eff[i] = 1'b0;
    hazard   = busy_eff[in_rs_a] | (~in_use_imm & busy_eff[in_rs_b]);
    in_ready = (out_ready | ~out_valid_q) & ~hazard & ~flush;
    accept   = in_valid & in_ready;
  end

  // Scoreboard update: clear on write-back, set on issue (set wins), flush clears all.
  always_comb begin
    busy_d = busy_eff;
    if (accept && in_wr) busy_d[in_rd] = 1'b1;
    if (flush)           busy_d = '0;
  end

  // Output register: load on accept, drain on consume, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_cop_d   = out_cop_q;
    out_rd_d    = out_rd_q;
    out_wr_d    = out_wr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = rd_a;
      out_b_d     = in_use_imm ? in_imm : rd_b;
      out_cop_d   = in_cop;
      out_rd_d    = in_rd;
      out_wr_d    = in_wr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  // Stage flops; reset drops any held instruction outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_cop_q   <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_cop_q   <= out_cop_d;
      out_rd_q    <= out_rd_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_reg_A = out_a_q;
  assign out_reg_B = out_b_q;
  assign out_cop   = out_cop_q;
  assign out_rd    = out_rd_q;
  assign out_wr    = out_wr_q;
endmodule

// File: tb/tb_regread_stage.sv
// Directed bench for regread_stage: vector table plus hazard/stall/flush/reset sequences.
module tb_regread_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_cop;
  logic [2:0]  in_rs_a, in_rs_b, in_rd;
  logic        in_wr, in_use_imm;
  logic [15:0] in_imm;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [15:0] out_reg_A, out_reg_B;
  logic [3:0]  out_cop;
  logic [2:0]  out_rd;
  logic        out_wr;

  int checks = 0;
  int errors = 0;

  regread_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cop(in_cop),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd), .in_wr(in_wr),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_A(out_reg_A), .out_reg_B(out_reg_B), .out_cop(out_cop),
    .out_rd(out_rd), .out_wr(out_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cop;
    logic [2:0]  rs_a, rs_b, rd;
    logic        wr, use_imm;
    logic [15:0] imm;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_cop = 0; in_rs_a = 0; in_rs_b = 0; in_rd = 0;
    in_wr = 0; in_use_imm = 0; in_imm = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic wb(input logic [2:0] r, input logic [15:0] d);
    wb_en = 1; wb_rd = r; wb_data = d;
  endtask

  task automatic issue(input logic [3:0] cop, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] rd, input logic wr, input logic ui, input logic [15:0] imm);
    in_valid = 1; in_cop = cop; in_rs_a = a; in_rs_b = b; in_rd = rd;
    in_wr = wr; in_use_imm = ui; in_imm = imm;
  endtask

  initial begin
    vecs[0] = '{4'b0010, 3'd1, 3'd6, 3'd4, 1'b0, 1'b0, 16'h0000, 16'h1111, 16'hA5A5};
    vecs[1] = '{4'b0011, 3'd7, 3'd0, 3'd1, 1'b0, 1'b1, 16'h00FF, 16'h7FFF, 16'h00FF};
    vecs[2] = '{4'b0100, 3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[3] = '{4'b0001, 3'd0, 3'd7, 3'd7, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7FFF};
    vecs[4] = '{4'b0000, 3'd6, 3'd1, 3'd5, 1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'hFFFF};

    // Reset state
    idle();
    rst_n = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_A", 32'(out_reg_A), 0);
    chk("rst_out_B", 32'(out_reg_B), 0);
    chk("rst_out_cop_rd_wr", {out_cop, out_rd, out_wr}, 0);
    tick(); tick();
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Reset test: write r3, issue ADD next cycle
    wb(3'd3, 16'h1234);
    tick();
    idle();
    issue(4'b0001, 3'd3, 3'd0, 3'd0, 0, 0, 0);
    tick();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_A", 32'(out_reg_A), 32'h1234);
    chk("add_B", 32'(out_reg_B), 0);
    chk("add_cop", 32'(out_cop), 1);

    // Bypass test: write r2 while reading it
    idle();
    wb(3'd2, 16'hBEEF);
    issue(4'b0001, 3'd2, 3'd3, 3'd0, 0, 0, 0);
    tick();
    chk("bypass_A", 32'(out_reg_A), 32'hBEEF);
    chk("bypass_B", 32'(out_reg_B), 32'h1234);

    // Preload remaining registers for the table
    idle(); wb(3'd1, 16'h1111); tick();
    idle(); wb(3'd6, 16'hA5A5); tick();
    idle(); wb(3'd7, 16'h7FFF); tick();
    idle();

    // Table-driven vectors, back-to-back issue
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].cop, vecs[i].rs_a, vecs[i].rs_b, vecs[i].rd, vecs[i].wr,
            vecs[i].use_imm, vecs[i].imm);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_A", i), 32'(out_reg_A), 32'(vecs[i].exp_a));
      chk($sformatf("vec%0d_B", i), 32'(out_reg_B), 32'(vecs[i].exp_b));
      chk($sformatf("vec%0d_cop", i), 32'(out_cop), 32'(vecs[i].cop));
      chk($sformatf("vec%0d_rd_wr", i), {out_rd, out_wr}, {vecs[i].rd, vecs[i].wr});
    end
    idle(); tick();
    chk("drain_valid", 32'(out_valid), 0);

    // RAW hazard: producer writes r5, consumer reads r5
    issue(4'b0001, 3'd0, 3'd0, 3'd5, 1, 0, 0);
    tick();
    chk("raw_prod_wr", {out_rd, out_wr}, {3'd5, 1'b1});
    issue(4'b0010, 3'd5, 3'd1, 3'd0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("raw_stall%0d", c), 32'(in_ready), 0);
      tick();
    end
    chk("raw_drained", 32'(out_valid), 0);
    wb(3'd5, 16'h5555);
    #1;
    chk("raw_wb_ready", 32'(in_ready), 1);
    tick();
    chk("raw_valid", 32'(out_valid), 1);
    chk("raw_A", 32'(out_reg_A), 32'h5555);
    chk("raw_B", 32'(out_reg_B), 32'h1111);
    wb_en = 0;

    // Stall: held instruction, downstream not ready
    out_ready = 0;
    issue(4'b0011, 3'd1, 3'd6, 3'd2, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 0);
      tick();
      chk($sformatf("stall%0d_hold", c), {out_valid, out_reg_A, out_reg_B, out_cop},
          {1'b1, 16'h5555, 16'h1111, 4'b0010});
    end
    out_ready = 1;
    #1;
    chk("stall_release_ready", 32'(in_ready), 1);
    tick();
    chk("stall_next_A", 32'(out_reg_A), 32'h1111);
    chk("stall_next_cop", 32'(out_cop), 3);

    // Immediate: rs_b busy but unused
    issue(4'b0001, 3'd0, 3'd0, 3'd3, 1, 0, 0);
    tick();
    issue(4'b0001, 3'd1, 3'd3, 3'd0, 0, 1, 16'hFFFF);
    #1;
    chk("imm_no_stall", 32'(in_ready), 1);
    tick();
    chk("imm_B", 32'(out_reg_B), 32'hFFFF);
    chk("imm_A", 32'(out_reg_A), 32'h1111);
    in_use_imm = 0;
    #1;
    chk("imm_rsb_busy_when_used", 32'(in_ready), 0);

    // Flush: r4 busy and held instruction; wb in flush cycle still writes
    issue(4'b0001, 3'd0, 3'd0, 3'd4, 1, 1, 0);
    tick();
    issue(4'b0001, 3'd4, 3'd3, 3'd0, 0, 0, 0);
    flush = 1;
    wb(3'd6, 16'h4444);
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    tick();
    chk("flush_valid", 32'(out_valid), 0);
    flush = 0; wb_en = 0;
    #1;
    chk("flush_busy_clear", 32'(in_ready), 1);
    tick();
    chk("post_flush_A", 32'(out_reg_A), 0);
    chk("post_flush_B", 32'(out_reg_B), 32'h1234);
    idle();
    issue(4'b0000, 3'd6, 3'd7, 3'd0, 0, 0, 0);
    tick();
    chk("flush_wb_written", {out_reg_A, out_reg_B}, {16'h4444, 16'h7FFF});

    // Mid-operation reset: held instruction dropped, register file cleared
    idle();
    out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_A", 32'(out_reg_A), 0);
    tick();
    rst_n = 1;
    out_ready = 1;
    issue(4'b0001, 3'd7, 3'd6, 3'd0, 0, 0, 0);
    #1;
    chk("midrst_ready", 32'(in_ready), 1);
    tick();
    chk("midrst_rf_clear", {out_valid, out_reg_A, out_reg_B}, {1'b1, 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
